// File: rtl/v_init_check.sv
// Read-back checker that sweeps an N-entry memory through its read port and
// compares every returned word against EXP, reporting pass/fail and error info.
module v_init_check #(
  parameter int             N         = 16,
  parameter int             W         = 32,
  parameter int             RD_LAT    = 1,
  parameter logic [W-1:0]   EXP       = '0,
  parameter int             ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       o_rd_en_r,
  output logic [$clog2(N)-1:0]       o_rd_addr_r,
  input  logic [W-1:0]               i_rd_data,
  input  logic                       i_start,
  output logic                       o_busy_r,
  output logic                       o_done_r,
  output logic                       o_pass_r,
  output logic                       o_err_vld_r,
  output logic [$clog2(N)-1:0]       o_err_addr_r,
  output logic [ERR_CNT_W-1:0]       o_err_cnt_r
);

  localparam int AW = $clog2(N);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                      state_q, state_d;
  logic                        rd_en_q, rd_en_d;
  logic [AW-1:0]               rd_addr_q, rd_addr_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        pass_q, pass_d;
  logic                        err_vld_q, err_vld_d;
  logic [AW-1:0]               err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic [RD_LAT-1:0]           pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][AW-1:0]   pipe_addr_q, pipe_addr_d;
  logic                        cmp_vld;
  logic [AW-1:0]               cmp_addr;
  logic                        mismatch;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_vld_d   = err_vld_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;

    // Return-tracking pipe: the tail entry lines up with i_rd_data this cycle.
    pipe_vld_d     = '0;
    pipe_addr_d    = '0;
    pipe_vld_d[0]  = rd_en_q;
    pipe_addr_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    cmp_vld  = pipe_vld_q[RD_LAT-1];
    cmp_addr = pipe_addr_q[RD_LAT-1];
    mismatch = cmp_vld && (i_rd_data != EXP);

    if (mismatch) begin
      err_cnt_d = sat_inc(err_cnt_q);
      if (!err_vld_q) begin
        err_vld_d  = 1'b1;
        err_addr_d = cmp_addr;
      end
    end

    case (state_q)
      IDLE: ;
      ISSUE: begin
        if (rd_addr_q == AW'(N - 1)) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        // Leave once nothing remains behind the compare happening on this edge.
        if (pipe_vld_d == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end
      end
      DONE: ;
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A start restarts from any state and discards every in-flight return.
    if (i_start) begin
      state_d    = ISSUE;
      rd_en_d    = 1'b1;
      rd_addr_d  = '0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      err_vld_d  = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = '0;
      pipe_vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_vld_q   <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_vld_q   <= err_vld_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

  assign o_rd_en_r    = rd_en_q;
  assign o_rd_addr_r  = rd_addr_q;
  assign o_busy_r     = busy_q;
  assign o_done_r     = done_q;
  assign o_pass_r     = pass_q;
  assign o_err_vld_r  = err_vld_q;
  assign o_err_addr_r = err_addr_q;
  assign o_err_cnt_r  = err_cnt_q;

endmodule
